// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder family.
// Holds default sizing and the legal lookahead group-size check.
package cla_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 4;

  // Lookahead groups are limited to sizes whose sum-of-products carries stay shallow.
  function automatic bit group_is_legal(input int group);
    return (group == 2) || (group == 4) || (group == 8);
  endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: carry into every bit from a single group carry-in,
// plus the group propagate/generate terms (generate assumes zero carry-in).
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] p,
  input  logic [GROUP-1:0] g,
  input  logic             ci,
  output logic [GROUP-1:0] c,
  output logic             pg,
  output logic             gg
);

  // Flat sum-of-products: c_n = G_{n-1} | P_{n-1}G_{n-2} | ... | P_{n-1..0}ci
  function automatic logic lookahead(input logic [GROUP-1:0] pv,
                                     input logic [GROUP-1:0] gv,
                                     input logic             cv,
                                     input int               n);
    logic res;
    logic term;
    res = cv;
    for (int j = 0; j < n; j++) res = res & pv[j];
    for (int k = 0; k < n; k++) begin
      term = gv[k];
      for (int j = k + 1; j < n; j++) term = term & pv[j];
      res = res | term;
    end
    return res;
  endfunction

  for (genvar gi = 0; gi < GROUP; gi++) begin : g_carry
    assign c[gi] = lookahead(p, g, ci, gi);
  end

  assign pg = &p;
  assign gg = lookahead(p, g, 1'b0, GROUP);

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control: stage 1 forms bit and group P/G, stage 2 resolves carries and sums.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             pg,
  output logic             gg
);

  localparam int NGROUP = WIDTH / GROUP;

  if (!group_is_legal(GROUP) || (WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP and GROUP must be 2, 4 or 8");
  end

  logic s1_valid;
  logic s2_valid;
  logic adv1;
  logic adv2;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  // ---------------- stage 1: operand conditioning and group P/G ----------------
  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  p_in;
  logic [WIDTH-1:0]  g_in;
  logic              c0_in;
  logic [NGROUP-1:0] pgk_in;
  logic [NGROUP-1:0] ggk_in;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub | cin;
  assign p_in  = a ^ b_eff;
  assign g_in  = a & b_eff;

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_s1
    logic gen;
    always_comb begin
      gen = 1'b0;
      for (int j = 0; j < GROUP; j++) gen = g_in[gi*GROUP+j] | (p_in[gi*GROUP+j] & gen);
    end
    assign pgk_in[gi] = &p_in[gi*GROUP +: GROUP];
    assign ggk_in[gi] = gen;
  end

  logic [WIDTH-1:0]  p_reg;
  logic [WIDTH-1:0]  g_reg;
  logic [NGROUP-1:0] pgk_reg;
  logic [NGROUP-1:0] ggk_reg;
  logic              c0_reg;

  // ---------------- stage 2: carry resolution ----------------
  logic [NGROUP:0]   grp_c;
  logic [WIDTH-1:0]  bit_c;
  logic [NGROUP-1:0] blk_pg;
  logic [NGROUP-1:0] blk_gg;
  logic [WIDTH-1:0]  sum_next;
  logic              cout_next;
  logic              ovf_next;
  logic              pg_next;
  logic              gg_next;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = c0_reg;
    for (int k = 0; k < NGROUP; k++) grp_c[k+1] = ggk_reg[k] | (pgk_reg[k] & grp_c[k]);
  end

  for (genvar gi = 0; gi < NGROUP; gi++) begin : g_s2
    cla_group #(
      .GROUP (GROUP)
    ) u_group (
      .p  (p_reg[gi*GROUP +: GROUP]),
      .g  (g_reg[gi*GROUP +: GROUP]),
      .ci (grp_c[gi]),
      .c  (bit_c[gi*GROUP +: GROUP]),
      .pg (blk_pg[gi]),
      .gg (blk_gg[gi])
    );
  end

  // Block generate is the group-level lookahead with the carry-in forced to zero.
  always_comb begin
    gg_next = 1'b0;
    for (int k = 0; k < NGROUP; k++) gg_next = blk_gg[k] | (blk_pg[k] & gg_next);
  end

  assign pg_next   = &blk_pg;
  assign sum_next  = p_reg ^ bit_c;
  assign cout_next = grp_c[NGROUP];
  assign ovf_next  = grp_c[NGROUP] ^ bit_c[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      p_reg    <= '0;
      g_reg    <= '0;
      pgk_reg  <= '0;
      ggk_reg  <= '0;
      c0_reg   <= 1'b0;
      s2_valid <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
      pg       <= 1'b0;
      gg       <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          p_reg   <= p_in;
          g_reg   <= g_in;
          pgk_reg <= pgk_in;
          ggk_reg <= ggk_in;
          c0_reg  <= c0_in;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          sum  <= sum_next;
          cout <= cout_next;
          ovf  <= ovf_next;
          pg   <= pg_next;
          gg   <= gg_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench: directed vectors, backpressure and reset sequences on a
// 32/4 instance, plus randomized streaming on 32/4 and 16/8 against an arithmetic model.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        pg;
    logic        gg;
  } res_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, ir32, cin32 = 1'b0, sub32 = 1'b0, ov32, or32 = 1'b1;
  logic        cout32, ovf32, pg32, gg32;
  logic [31:0] a32 = '0, b32 = '0, sum32;

  logic        iv16 = 1'b0, ir16, cin16 = 1'b0, sub16 = 1'b0, ov16, or16 = 1'b1;
  logic        cout16, ovf16, pg16, gg16;
  logic [15:0] a16 = '0, b16 = '0, sum16;

  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
    .cout(cout32), .ovf(ovf32), .pg(pg32), .gg(gg32)
  );

  cla_pipe_adder #(.WIDTH(16), .GROUP(8)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(or16), .sum(sum16),
    .cout(cout16), .ovf(ovf16), .pg(pg16), .gg(gg16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_res(input string name, input res_t act, input res_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got sum=%h cout=%b ovf=%b pg=%b gg=%b, expected sum=%h cout=%b ovf=%b pg=%b gg=%b",
               name, act.sum, act.cout, act.ovf, act.pg, act.gg,
               exp.sum, exp.cout, exp.ovf, exp.pg, exp.gg);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the effective operands.
  function automatic res_t ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub);
    logic [32:0] mask, beff, full, nocin;
    res_t r;
    mask   = (33'd1 << w) - 33'd1;
    beff   = {1'b0, (sub ? ~b : b)} & mask;
    full   = {1'b0, a} + beff + {32'd0, (sub ? 1'b1 : cin)};
    nocin  = {1'b0, a} + beff;
    r.sum  = full[31:0] & mask[31:0];
    r.cout = full[w];
    r.ovf  = (a[w-1] == beff[w-1]) && (r.sum[w-1] != a[w-1]);
    r.pg   = ((({1'b0, a}) ^ beff) & mask) == mask;
    r.gg   = nocin[w];
    return r;
  endfunction

  function automatic res_t got32();
    return res_t'({sum32, cout32, ovf32, pg32, gg32});
  endfunction

  function automatic res_t got16();
    return res_t'({16'h0, sum16, cout16, ovf16, pg16, gg16});
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic cin, input logic sub, input logic [31:0] s,
                              input logic co, input logic ov, input logic p, input logic g);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.cin = cin; v.sub = sub;
    v.exp  = res_t'({s, co, ov, p, g});
    return v;
  endfunction

  function automatic logic [31:0] rand_op(input int w);
    logic [31:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    case (sel)
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h1 << (w - 1);
      3:       v = ~(32'h1 << (w - 1));
      default: v = $urandom;
    endcase
    if (w < 32) v = v & ((32'h1 << w) - 32'h1);
    return v;
  endfunction

  vec_t tbl[10];
  res_t q32[$];
  res_t q16[$];

  initial begin
    int acc32, acc16, cyc;
    tbl[0] = mk("carry_ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    tbl[1] = mk("full_prop_c1",  32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[2] = mk("full_prop_c0",  32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk("sub_5_7",       32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[4] = mk("sub_min_1",     32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5] = mk("add_max_1",     32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tbl[6] = mk("sub_5_7_cin",   32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk("sub_min_1_cin", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[8] = mk("zero_cin",      32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[9] = mk("sub_self",      32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("reset_out_valid", ov32, 1'b0);
    check_res("reset_outputs", got32(), '0);
    check_bit("reset_out_valid16", ov16, 1'b0);
    rst = 1'b0;

    // Directed vectors, one at a time, with exact latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv32 = 1'b1; a32 = tbl[i].a; b32 = tbl[i].b; cin32 = tbl[i].cin; sub32 = tbl[i].sub;
      #1 check_bit({tbl[i].name, "_in_ready"}, ir32, 1'b1);
      @(negedge clk);
      iv32 = 1'b0;
      #1 check_bit({tbl[i].name, "_early"}, ov32, 1'b0);
      @(negedge clk);
      #1 check_bit({tbl[i].name, "_valid"}, ov32, 1'b1);
      check_res(tbl[i].name, got32(), tbl[i].exp);
      $display("vec %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b pg=%b gg=%b",
               tbl[i].name, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
               sum32, cout32, ovf32, pg32, gg32);
    end

    // Backpressure: two ops fill the pipe, output holds while stalled
    @(negedge clk);
    or32 = 1'b0; iv32 = 1'b1; cin32 = 1'b0; sub32 = 1'b0; a32 = 32'd1; b32 = 32'd1;
    #1 check_bit("bp_ready1", ir32, 1'b1);
    @(negedge clk);
    a32 = 32'd2; b32 = 32'd2;
    #1 check_bit("bp_ready2", ir32, 1'b1);
    check_bit("bp_not_yet", ov32, 1'b0);
    @(negedge clk);
    a32 = 32'd3; b32 = 32'd3;
    #1 check_bit("bp_ready_low_a", ir32, 1'b0);
    check_bit("bp_hold_valid_a", ov32, 1'b1);
    check_word("bp_hold_sum_a", sum32, 32'd2);
    @(negedge clk);
    #1 check_bit("bp_ready_low_b", ir32, 1'b0);
    check_word("bp_hold_sum_b", sum32, 32'd2);
    @(negedge clk);
    #1 check_bit("bp_ready_low_c", ir32, 1'b0);
    check_bit("bp_hold_valid_c", ov32, 1'b1);
    check_word("bp_hold_sum_c", sum32, 32'd2);
    or32 = 1'b1;
    #1 check_bit("bp_ready_release", ir32, 1'b1);
    @(negedge clk);
    a32 = 32'd4; b32 = 32'd4;
    #1 check_bit("bp_out2_valid", ov32, 1'b1);
    check_word("bp_out2", sum32, 32'd4);
    check_bit("bp_ready4", ir32, 1'b1);
    @(negedge clk);
    iv32 = 1'b0;
    #1 check_bit("bp_out3_valid", ov32, 1'b1);
    check_word("bp_out3", sum32, 32'd6);
    @(negedge clk);
    #1 check_bit("bp_out4_valid", ov32, 1'b1);
    check_word("bp_out4", sum32, 32'd8);
    @(negedge clk);
    #1 check_bit("bp_drained", ov32, 1'b0);
    $display("backpressure: stream 2,4,6,8 checked");

    // Reset with both stages full
    @(negedge clk);
    or32 = 1'b0; iv32 = 1'b1; a32 = 32'd10; b32 = 32'd10;
    @(negedge clk);
    a32 = 32'd11; b32 = 32'd11;
    @(negedge clk);
    iv32 = 1'b0;
    #1 check_bit("rst_full_valid", ov32, 1'b1);
    rst = 1'b1;
    #1 check_bit("rst_async_valid", ov32, 1'b0);
    check_res("rst_async_outputs", got32(), '0);
    @(negedge clk);
    rst = 1'b0; or32 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_bit("rst_no_stale", ov32, 1'b0);
    end
    iv32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    #1 check_bit("rst_after_ready", ir32, 1'b1);
    @(negedge clk);
    iv32 = 1'b0;
    @(negedge clk);
    #1 check_bit("rst_after_valid", ov32, 1'b1);
    check_word("rst_after_sum", sum32, 32'd18);
    $display("reset mid-operation: flushed, next op sum=%h", sum32);

    // Randomized streaming on both configurations
    acc32 = 0; acc16 = 0; cyc = 0;
    while ((acc32 < 5000 || acc16 < 5000) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      iv32  = (acc32 < 5000) && ($urandom_range(0, 9) < 8);
      a32   = rand_op(32); b32 = rand_op(32);
      cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
      or32  = ($urandom_range(0, 9) < 7);
      iv16  = (acc16 < 5000) && ($urandom_range(0, 9) < 8);
      a16   = 16'(rand_op(16)); b16 = 16'(rand_op(16));
      cin16 = 1'($urandom_range(0, 1)); sub16 = 1'($urandom_range(0, 1));
      or16  = ($urandom_range(0, 9) < 7);
      #1;
      if (ov32 && or32) begin
        if (q32.size() == 0) check_bit("rand32_spurious", ov32, 1'b0);
        else begin
          check_res("rand32", got32(), q32.pop_front());
          $display("rand32 out: sum=%h cout=%b ovf=%b pg=%b gg=%b", sum32, cout32, ovf32, pg32, gg32);
        end
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) check_bit("rand16_spurious", ov16, 1'b0);
        else begin
          check_res("rand16", got16(), q16.pop_front());
          $display("rand16 out: sum=%h cout=%b ovf=%b pg=%b gg=%b", sum16, cout16, ovf16, pg16, gg16);
        end
      end
      if (or32) check_bit("rand32_throughput", ir32, 1'b1);
      if (or16) check_bit("rand16_throughput", ir16, 1'b1);
      if (iv32 && ir32) begin
        q32.push_back(ref_model(32, a32, b32, cin32, sub32));
        acc32++;
      end
      if (iv16 && ir16) begin
        q16.push_back(ref_model(16, {16'h0, a16}, {16'h0, b16}, cin16, sub16));
        acc16++;
      end
    end
    check_bit("rand32_all_accepted", acc32 == 5000, 1'b1);
    check_bit("rand16_all_accepted", acc16 == 5000, 1'b1);

    @(negedge clk);
    iv32 = 1'b0; iv16 = 1'b0; or32 = 1'b1; or16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ov32) begin
        if (q32.size() == 0) check_bit("drain32_spurious", ov32, 1'b0);
        else check_res("drain32", got32(), q32.pop_front());
      end
      if (ov16) begin
        if (q16.size() == 0) check_bit("drain16_spurious", ov16, 1'b0);
        else check_res("drain16", got16(), q16.pop_front());
      end
      @(negedge clk);
    end
    check_bit("drain32_empty", q32.size() == 0, 1'b1);
    check_bit("drain16_empty", q16.size() == 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
